// File: rtl/instr_fetch.sv
// Instruction fetch unit: one bus read per fetch through an IDLE/REQ/DONE FSM.
// Optional single-entry reuse buffer enabled by defining FETCH_REUSE_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] pc_addr,
    input  logic        fetch_en,
    input  logic        inval,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        iready,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_addr_next;
    logic [31:0] instr_reg;
    logic [31:0] instr_next;
    logic        aligned;
    logic        capture;
    logic        reuse_hit;

    assign aligned = (pc_addr[1:0] == 2'b00);
    assign capture = (state_reg == REQ) && mem_ack;

`ifdef FETCH_REUSE_EN
    logic [31:0] last_addr_reg;
    logic [31:0] last_addr_next;
    logic        last_valid_reg;
    logic        last_valid_next;

    assign reuse_hit = last_valid_reg && (pc_addr == last_addr_reg);

    // Invalidation wins over a capture in the same cycle.
    always_comb begin
        last_addr_next  = last_addr_reg;
        last_valid_next = last_valid_reg;
        if (capture) begin
            last_addr_next  = mem_addr_reg;
            last_valid_next = 1'b1;
        end
        if (inval) begin
            last_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            last_addr_reg  <= 32'h0;
            last_valid_reg <= 1'b0;
        end else begin
            last_addr_reg  <= last_addr_next;
            last_valid_reg <= last_valid_next;
        end
    end
`else
    logic unused_inval;

    assign unused_inval = inval;
    assign reuse_hit    = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        mem_addr_next = mem_addr_reg;
        instr_next    = instr_reg;
        case (state_reg)
            IDLE: begin
                if (fetch_en && aligned) begin
                    if (reuse_hit) begin
                        state_next = DONE;
                    end else begin
                        mem_addr_next = pc_addr;
                        state_next    = REQ;
                    end
                end
            end
            // The request is never abandoned; fetch_en is not looked at here.
            REQ: begin
                if (mem_ack) begin
                    instr_next = mem_rdata;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= IDLE;
            mem_addr_reg <= 32'h0;
            instr_reg    <= RESET_INSTR;
        end else begin
            state_reg    <= state_next;
            mem_addr_reg <= mem_addr_next;
            instr_reg    <= instr_next;
        end
    end

    // Both strobes decode from the state register, so they are mutually exclusive.
    assign mem_req   = (state_reg == REQ);
    assign iready    = (state_reg == DONE);
    assign mem_addr  = mem_addr_reg;
    assign instr     = instr_reg;
    assign fetch_err = (state_reg == IDLE) && fetch_en && !aligned;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table of fetch vectors plus reuse/reset sequences.
module tb_instr_fetch;

`ifdef FETCH_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] pc_addr = 32'h0;
    logic        fetch_en = 1'b0;
    logic        inval = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] instr;
    logic        iready;
    logic        fetch_err;

    int pass_count = 0;
    int check_count = 0;

    instr_fetch dut (
        .clk       (clk),
        .nRST      (nRST),
        .pc_addr   (pc_addr),
        .fetch_en  (fetch_en),
        .inval     (inval),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .instr     (instr),
        .iready    (iready),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          waits;
        bit          misaligned;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input vec_t v);
        pc_addr  = v.addr;
        fetch_en = 1'b1;
        #1;
        if (v.misaligned) begin
            check("misal_err", {31'b0, fetch_err}, 32'd1);
            check("misal_req", {31'b0, mem_req}, 32'd0);
            check("misal_rdy", {31'b0, iready}, 32'd0);
            step();
            check("misal_err_hold", {31'b0, fetch_err}, 32'd1);
            check("misal_req_hold", {31'b0, mem_req}, 32'd0);
            check("misal_rdy_hold", {31'b0, iready}, 32'd0);
            fetch_en = 1'b0;
            #1;
            check("misal_err_clr", {31'b0, fetch_err}, 32'd0);
            check("misal_instr", instr, v.exp_instr);
        end else begin
            check("fetch_err_low", {31'b0, fetch_err}, 32'd0);
            step();
            fetch_en = 1'b0;
            check("req_high", {31'b0, mem_req}, 32'd1);
            check("req_addr", mem_addr, v.addr);
            check("req_rdy_low", {31'b0, iready}, 32'd0);
            for (int w = 0; w < v.waits; w++) begin
                step();
                check("wait_req", {31'b0, mem_req}, 32'd1);
                check("wait_addr", mem_addr, v.addr);
                check("wait_rdy", {31'b0, iready}, 32'd0);
            end
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            step();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            check("done_rdy", {31'b0, iready}, 32'd1);
            check("done_req", {31'b0, mem_req}, 32'd0);
            check("done_instr", instr, v.exp_instr);
            step();
            check("post_rdy", {31'b0, iready}, 32'd0);
            check("post_instr", instr, v.exp_instr);
        end
    endtask

    task automatic refetch(input logic [31:0] addr, input bit hit, input logic [31:0] rdata,
                           input bit inval_on_ack, input logic [31:0] exp_instr);
        pc_addr  = addr;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        if (hit) begin
            check("hit_rdy", {31'b0, iready}, 32'd1);
            check("hit_req", {31'b0, mem_req}, 32'd0);
            check("hit_instr", instr, exp_instr);
            step();
            check("hit_post_rdy", {31'b0, iready}, 32'd0);
        end else begin
            check("miss_req", {31'b0, mem_req}, 32'd1);
            check("miss_rdy", {31'b0, iready}, 32'd0);
            check("miss_addr", mem_addr, addr);
            mem_ack   = 1'b1;
            mem_rdata = rdata;
            inval     = inval_on_ack;
            step();
            mem_ack = 1'b0;
            inval   = 1'b0;
            check("miss_done_rdy", {31'b0, iready}, 32'd1);
            check("miss_instr", instr, exp_instr);
            step();
        end
        $display("refetch addr=%h hit=%0d instr=%h", addr, hit, instr);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0050_0093, 3, 1'b0, 32'h0050_0093};
        vecs[1] = '{32'h0000_0104, 32'h00A0_0113, 0, 1'b0, 32'h00A0_0113};
        vecs[2] = '{32'h0000_0102, 32'h0,         0, 1'b1, 32'h00A0_0113};
        vecs[3] = '{32'h0000_01FC, 32'hFFF0_0193, 1, 1'b0, 32'hFFF0_0193};
        vecs[4] = '{32'h0000_0003, 32'h0,         0, 1'b1, 32'hFFF0_0193};
        vecs[5] = '{32'hFFFF_FFF0, 32'hDEAD_BEEF, 5, 1'b0, 32'hDEAD_BEEF};

        repeat (3) @(posedge clk);
        #1;
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        nRST = 1'b1;
        step();
        check("rel_instr", instr, 32'h0000_0013);
        check("rel_rdy", {31'b0, iready}, 32'd0);
        check("rel_req", {31'b0, mem_req}, 32'd0);
        check("rel_addr", mem_addr, 32'h0);

        for (int i = 0; i < 6; i++) begin
            do_fetch(vecs[i]);
            $display("fetch %0d addr=%h instr=%h", i, vecs[i].addr, instr);
        end

        // Reuse: hit, then invalidate and refetch, then inval coinciding with ack.
        refetch(32'hFFFF_FFF0, REUSE, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
        inval = 1'b1;
        step();
        inval = 1'b0;
        refetch(32'hFFFF_FFF0, 1'b0, 32'h1111_1111, 1'b0, 32'h1111_1111);
        refetch(32'hFFFF_FFF0, REUSE, 32'h1111_1111, 1'b0, 32'h1111_1111);
        refetch(32'h0000_0200, 1'b0, 32'h2222_2222, 1'b1, 32'h2222_2222);
        refetch(32'h0000_0200, 1'b0, 32'h3333_3333, 1'b0, 32'h3333_3333);

        // Stray ack while idle must not disturb anything.
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        step();
        mem_ack = 1'b0;
        check("stray_instr", instr, 32'h3333_3333);
        check("stray_rdy", {31'b0, iready}, 32'd0);
        step();
        check("stray_rdy2", {31'b0, iready}, 32'd0);
        $display("stray ack instr=%h", instr);

        // Reset in the middle of a request, then a late ack after release.
        pc_addr  = 32'h0000_0100;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        check("mid_req", {31'b0, mem_req}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, mem_req}, 32'd0);
        check("mid_rst_instr", instr, 32'h0000_0013);
        check("mid_rst_addr", mem_addr, 32'h0);
        step();
        nRST = 1'b1;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0050_0093;
        step();
        mem_ack = 1'b0;
        check("late_rdy", {31'b0, iready}, 32'd0);
        check("late_instr", instr, 32'h0000_0013);
        step();
        check("late_rdy2", {31'b0, iready}, 32'd0);
        check("late_req", {31'b0, mem_req}, 32'd0);
        $display("reset mid-request instr=%h", instr);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
